// File: rtl/uart_arb_pkg.sv
// Shared FSM states and width helpers for the UART TX arbiter.
// Pure types and functions; no timing or flow-control behaviour of its own.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_e;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_index(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/uart_arb_picker.sv
// Combinational winner select from (req, last); zero latency, no backpressure.
// UART_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module uart_arb_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [ID_W-1:0]    winner,
   output logic               valid
);

`ifdef UART_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;

   // Walk downwards so the lowest set index is the final assignment.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            valid  = 1'b1;
            winner = ID_W'(j);
         end
      end
   end
`else
   // Search starts one past the last winner and wraps, so last itself is checked last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j] && (j == rr_index(int'(last), i, NUM_REQ))) begin
               valid  = 1'b1;
               winner = ID_W'(j);
            end
         end
      end
   end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among NUM_REQ byte sources; grant/tx_start one cycle after the IDLE sample.
// Holds off while tx_busy is high; UART_ARB_FIXED_PRIO_EN switches the picker to fixed priority.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]  active_id,
   output logic                        err_timeout
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     active_id_q, active_id_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                tx_start_q, tx_start_d;
   logic                err_timeout_q, err_timeout_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [ID_W-1:0]     pick_id;
   logic                pick_vld;
   logic [DATA_W-1:0]   win_byte;

   uart_arb_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req     (req),
      .last    (last_q),
      .winner  (pick_id),
      .valid   (pick_vld)
   );

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_id == ID_W'(i)) begin
            win_byte = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      active_id_d   = active_id_q;
      tx_data_d     = tx_data_q;
      grant_d       = '0;
      tx_start_d    = 1'b0;
      err_timeout_d = 1'b0;
      cnt_d         = cnt_q;

      case (state_q)
         IDLE: begin
            // A busy core in IDLE is someone else's frame; wait it out.
            if (pick_vld && !tx_busy) begin
               state_d          = START;
               last_d           = pick_id;
               active_id_d      = pick_id;
               tx_data_d        = win_byte;
               grant_d[pick_id] = 1'b1;
               tx_start_d       = 1'b1;
            end
         end
         START: begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Byte is dropped, not retried: the requester already saw its grant.
               state_d       = IDLE;
               err_timeout_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_q        <= LAST_RST;
         active_id_q   <= '0;
         tx_data_q     <= '0;
         grant_q       <= '0;
         tx_start_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         active_id_q   <= active_id_d;
         tx_data_q     <= tx_data_d;
         grant_q       <= grant_d;
         tx_start_q    <= tx_start_d;
         err_timeout_q <= err_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign grant       = grant_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign active_id   = active_id_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of arbitration rounds plus
// hand sequences for timeout, foreign busy, async reset and dropped requests.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  active_id;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .NUM_REQ (4),
      .DATA_W  (8),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (req_data),
      .grant       (grant),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .active_id   (active_id),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] data;
      int          exp_rr;
      int          exp_fx;
      int          dly;
      int          len;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic int pick_exp(input int rr, input int fx);
`ifdef UART_ARB_FIXED_PRIO_EN
      return fx;
`else
      return rr;
`endif
   endfunction

   // Drive a request in IDLE, check the grant round, then emulate the TX core frame.
   task automatic run_txn(input logic [3:0] mask, input logic [31:0] data, input int exp,
                          input int dly, input int len, input string tag);
      int         lat;
      logic [7:0] eb;
      logic [3:0] eg;
      bit         held;
      eb = data[exp*8 +: 8];
      eg = 4'b0001 << exp;
      req      = mask;
      req_data = data;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!tx_start && lat < 30);
      chk({tag, " start latency"}, 32'(lat), 32'd1);
      chk({tag, " grant"}, 32'(grant), 32'(eg));
      chk({tag, " active_id"}, 32'(active_id), 32'(exp));
      chk({tag, " tx_data"}, 32'(tx_data), 32'(eb));
      req = 4'b0000;
      @(negedge clk);
      chk({tag, " pulse width"}, 32'({tx_start, grant}), 32'd0);
      for (int d = 1; d < dly; d++) @(negedge clk);
      tx_busy = 1'b1;
      held = 1'b1;
      for (int l = 0; l < len; l++) begin
         @(negedge clk);
         if (tx_data !== eb || tx_start !== 1'b0 || err_timeout !== 1'b0) held = 1'b0;
      end
      chk({tag, " data held during frame"}, 32'(held), 32'd1);
      tx_busy = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int         n;
      bit         quiet;
      logic [7:0] eb;

      vecs[0] = '{4'b1111, 32'hD3C2B1A0, 0, 0, 1, 4};
      vecs[1] = '{4'b1111, 32'hD3C2B1A0, 1, 0, 1, 4};
      vecs[2] = '{4'b1111, 32'hD3C2B1A0, 2, 0, 1, 4};
      vecs[3] = '{4'b1111, 32'hD3C2B1A0, 3, 0, 1, 4};
      vecs[4] = '{4'b1111, 32'hD3C2B1A0, 0, 0, 1, 4};
      vecs[5] = '{4'b0100, 32'h77416655, 2, 2, 3, 20};
      vecs[6] = '{4'b0100, 32'h775A6655, 2, 2, 1, 4};
      vecs[7] = '{4'b1001, 32'h99000011, 3, 0, 2, 3};
      vecs[8] = '{4'b1001, 32'h98000012, 0, 0, 1, 3};
      vecs[9] = '{4'b0010, 32'h00003C00, 1, 1, 1, 2};

      rst_n    = 1'b0;
      req      = 4'b0000;
      req_data = 32'h0;
      tx_busy  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset tx_start", 32'(tx_start), 32'd0);
      chk("reset tx_data", 32'(tx_data), 32'd0);
      chk("reset active_id", 32'(active_id), 32'd0);
      chk("reset err_timeout", 32'(err_timeout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 10; k++) begin
         run_txn(vecs[k].mask, vecs[k].data, pick_exp(vecs[k].exp_rr, vecs[k].exp_fx),
                 vecs[k].dly, vecs[k].len, $sformatf("vec%0d", k));
      end

      // Timeout: core never goes busy.
      req      = 4'b0001;
      req_data = 32'h000000E7;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_start && n < 30);
      chk("timeout start latency", 32'(n), 32'd1);
      chk("timeout grant", 32'(grant), 32'h1);
      req = 4'b0000;
      n = 0;
      quiet = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (tx_start || grant != 4'b0000) quiet = 1'b0;
      end while (!err_timeout && n < 40);
      chk("timeout err delay", 32'(n), 32'd17);
      chk("timeout quiet while waiting", 32'(quiet), 32'd1);
      @(negedge clk);
      chk("timeout err pulse width", 32'(err_timeout), 32'd0);
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (tx_start || grant != 4'b0000 || err_timeout) quiet = 1'b0;
      end
      chk("timeout no retry", 32'(quiet), 32'd1);

      // Foreign busy from reset holds off the grant.
      rst_n    = 1'b0;
      tx_busy  = 1'b1;
      req      = 4'b0010;
      req_data = 32'h00005100;
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (tx_start || grant != 4'b0000) quiet = 1'b0;
      end
      chk("busy-from-reset no start", 32'(quiet), 32'd1);
      tx_busy = 1'b0;
      @(negedge clk);
      chk("busy-from-reset start after drop", 32'(tx_start), 32'd1);
      chk("busy-from-reset grant", 32'(grant), 32'h2);
      chk("busy-from-reset tx_data", 32'(tx_data), 32'h51);
      req = 4'b0000;
      @(negedge clk);
      tx_busy = 1'b1;
      repeat (3) @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);

      // Async reset while tx_start is high.
      req      = 4'b1000;
      req_data = 32'hA5000000;
      @(posedge clk);
      #2;
      chk("start before reset", 32'(tx_start), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("reset drops tx_start", 32'(tx_start), 32'd0);
      chk("reset drops grant", 32'(grant), 32'd0);
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Async reset during WAIT_DONE.
      req = 4'b1000;
      @(negedge clk);
      chk("wait_done setup start", 32'(tx_start), 32'd1);
      chk("wait_done setup tx_data", 32'(tx_data), 32'hA5);
      req = 4'b0000;
      @(negedge clk);
      tx_busy = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset in frame tx_data", 32'(tx_data), 32'd0);
      chk("reset in frame active_id", 32'(active_id), 32'd0);
      tx_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(4'b1001, 32'h3C0000C3, 0, 1, 3, "post-reset");

      // Request withdrawn before IDLE could sample it.
      tx_busy = 1'b1;
      req     = 4'b0010;
      repeat (3) @(negedge clk);
      req     = 4'b0000;
      tx_busy = 1'b0;
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (tx_start || grant != 4'b0000) quiet = 1'b0;
      end
      chk("dropped req no grant", 32'(quiet), 32'd1);
      chk("dropped req active_id", 32'(active_id), 32'd0);
      eb = 8'h6D;
      run_txn(4'b0110, {8'h00, 8'h99, eb, 8'h00}, 1, 1, 2, "pointer unmoved");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
